// File: rtl/id_ex_hazard_reg_if.sv
// ID-to-EX pipeline bus: decoded fields from the ID stage, registered fields to EX,
// plus the stall request back to PC/IF-ID and the bubble counter.
interface id_ex_hazard_reg_if #(
  parameter int XLEN  = 64,
  parameter int RA_W  = 5,
  parameter int CNT_W = 16
);
  logic            id_valid;
  logic            id_flush;
  logic            id_alusrc;
  logic            id_memtoreg;
  logic            id_regwrite;
  logic            id_memread;
  logic            id_memwrite;
  logic            id_branch;
  logic [1:0]      id_aluop;
  logic [XLEN-1:0] id_rs1_data;
  logic [XLEN-1:0] id_rs2_data;
  logic [XLEN-1:0] id_imm;
  logic [XLEN-1:0] id_pc;
  logic [RA_W-1:0] id_rs1;
  logic [RA_W-1:0] id_rs2;
  logic [RA_W-1:0] id_rd;
  logic [3:0]      id_funct;

  logic            ex_valid;
  logic            ex_alusrc;
  logic            ex_memtoreg;
  logic            ex_regwrite;
  logic            ex_memread;
  logic            ex_memwrite;
  logic            ex_branch;
  logic [1:0]      ex_aluop;
  logic [XLEN-1:0] ex_rs1_data;
  logic [XLEN-1:0] ex_rs2_data;
  logic [XLEN-1:0] ex_imm;
  logic [XLEN-1:0] ex_pc;
  logic [RA_W-1:0] ex_rs1;
  logic [RA_W-1:0] ex_rs2;
  logic [RA_W-1:0] ex_rd;
  logic [3:0]      ex_funct;

  logic             stall;
  logic [CNT_W-1:0] bubble_cnt;

  modport master (
    output id_valid, id_flush, id_alusrc, id_memtoreg, id_regwrite, id_memread,
           id_memwrite, id_branch, id_aluop, id_rs1_data, id_rs2_data, id_imm,
           id_pc, id_rs1, id_rs2, id_rd, id_funct,
    input  ex_valid, ex_alusrc, ex_memtoreg, ex_regwrite, ex_memread,
           ex_memwrite, ex_branch, ex_aluop, ex_rs1_data, ex_rs2_data, ex_imm,
           ex_pc, ex_rs1, ex_rs2, ex_rd, ex_funct, stall, bubble_cnt
  );

  modport slave (
    input  id_valid, id_flush, id_alusrc, id_memtoreg, id_regwrite, id_memread,
           id_memwrite, id_branch, id_aluop, id_rs1_data, id_rs2_data, id_imm,
           id_pc, id_rs1, id_rs2, id_rd, id_funct,
    output ex_valid, ex_alusrc, ex_memtoreg, ex_regwrite, ex_memread,
           ex_memwrite, ex_branch, ex_aluop, ex_rs1_data, ex_rs2_data, ex_imm,
           ex_pc, ex_rs1, ex_rs2, ex_rd, ex_funct, stall, bubble_cnt
  );
endinterface

// File: rtl/id_ex_hazard_reg.sv
// ID/EX pipeline register with load-use hazard detection, bubble injection on
// hazard or branch flush, and a saturating count of injected bubbles.
module id_ex_hazard_reg #(
  parameter int XLEN  = 64,
  parameter int RA_W  = 5,
  parameter int CNT_W = 16
) (
  input logic              clk,
  input logic              rst,
  id_ex_hazard_reg_if.slave bus
);

  typedef struct packed {
    logic            valid;
    logic            alusrc;
    logic            memtoreg;
    logic            regwrite;
    logic            memread;
    logic            memwrite;
    logic            branch;
    logic [1:0]      aluop;
    logic [XLEN-1:0] rs1Data;
    logic [XLEN-1:0] rs2Data;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc;
    logic [RA_W-1:0] rs1;
    logic [RA_W-1:0] rs2;
    logic [RA_W-1:0] rd;
    logic [3:0]      funct;
  } stage_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  stage_t           stage_q, stage_d;
  logic [CNT_W-1:0] bubbleCnt_q, bubbleCnt_d;
  logic             hazard;
  logic             bubble;

  // A load in EX whose destination is read by ID must wait one cycle; rs2 is
  // compared even for formats that do not use it, which only costs an extra stall.
  always_comb begin
    hazard = bus.id_valid & stage_q.valid & stage_q.memread & (stage_q.rd != '0) &
             ((stage_q.rd == bus.id_rs1) | (stage_q.rd == bus.id_rs2));
    bubble = bus.id_flush | hazard;

    stage_d     = '0;
    bubbleCnt_d = bubbleCnt_q;
    if (bubble) begin
      if (bubbleCnt_q != CNT_MAX) bubbleCnt_d = bubbleCnt_q + CNT_W'(1);
    end else begin
      stage_d.valid   = bus.id_valid;
      stage_d.aluop   = bus.id_valid ? bus.id_aluop : 2'b00;
      stage_d.rs1Data = bus.id_rs1_data;
      stage_d.rs2Data = bus.id_rs2_data;
      stage_d.imm     = bus.id_imm;
      stage_d.pc      = bus.id_pc;
      stage_d.rs1     = bus.id_rs1;
      stage_d.rs2     = bus.id_rs2;
      stage_d.rd      = bus.id_rd;
      stage_d.funct   = bus.id_funct;
      if (bus.id_valid) begin
        stage_d.alusrc   = bus.id_alusrc;
        stage_d.memtoreg = bus.id_memtoreg;
        stage_d.regwrite = bus.id_regwrite;
        stage_d.memread  = bus.id_memread;
        stage_d.memwrite = bus.id_memwrite;
        stage_d.branch   = bus.id_branch;
      end
    end
  end

  // A flush kills the ID instruction outright, so it must not also hold the front end.
  assign bus.stall = hazard & ~bus.id_flush & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      stage_q     <= '0;
      bubbleCnt_q <= '0;
    end else begin
      stage_q     <= stage_d;
      bubbleCnt_q <= bubbleCnt_d;
    end
  end

  assign bus.ex_valid    = stage_q.valid;
  assign bus.ex_alusrc   = stage_q.alusrc;
  assign bus.ex_memtoreg = stage_q.memtoreg;
  assign bus.ex_regwrite = stage_q.regwrite;
  assign bus.ex_memread  = stage_q.memread;
  assign bus.ex_memwrite = stage_q.memwrite;
  assign bus.ex_branch   = stage_q.branch;
  assign bus.ex_aluop    = stage_q.aluop;
  assign bus.ex_rs1_data = stage_q.rs1Data;
  assign bus.ex_rs2_data = stage_q.rs2Data;
  assign bus.ex_imm      = stage_q.imm;
  assign bus.ex_pc       = stage_q.pc;
  assign bus.ex_rs1      = stage_q.rs1;
  assign bus.ex_rs2      = stage_q.rs2;
  assign bus.ex_rd       = stage_q.rd;
  assign bus.ex_funct    = stage_q.funct;
  assign bus.bubble_cnt  = bubbleCnt_q;

endmodule

// File: tb/tb_id_ex_hazard_reg.sv
// Scoreboard bench for id_ex_hazard_reg: directed load-use/flush/saturation
// sequences followed by random traffic, checked against an instruction-level model.
module tb_id_ex_hazard_reg;

  localparam int XLEN    = 64;
  localparam int RA_W    = 5;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  typedef struct packed {
    logic        valid;
    logic        alusrc;
    logic        memtoreg;
    logic        regwrite;
    logic        memread;
    logic        memwrite;
    logic        branch;
    logic [1:0]  aluop;
    logic [63:0] rs1Data;
    logic [63:0] rs2Data;
    logic [63:0] imm;
    logic [63:0] pc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [3:0]  funct;
  } instr_t;

  typedef struct {
    instr_t ex;
    logic   stall;
    int     cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst;

  id_ex_hazard_reg_if #(.XLEN(XLEN), .RA_W(RA_W), .CNT_W(CNT_W)) bus ();

  id_ex_hazard_reg #(.XLEN(XLEN), .RA_W(RA_W), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  exp_t   sbQ[$];
  instr_t mEx;
  int     mCnt;
  logic   modelKnown = 1'b0;
  logic   running    = 1'b0;
  logic   lastStall  = 1'b0;
  int     nChecks    = 0;
  int     nFails     = 0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Instruction-level view: a valid load in EX blocks any valid ID instruction reading its nonzero rd.
  function automatic logic loadUse(input instr_t ex, input instr_t id);
    return id.valid && ex.valid && ex.memread && (ex.rd != 5'd0) &&
           ((ex.rd == id.rs1) || (ex.rd == id.rs2));
  endfunction

  function automatic instr_t randInstr();
    instr_t r;
    r.valid    = ($urandom_range(0, 9) != 0);
    r.alusrc   = 1'($urandom);
    r.memtoreg = 1'($urandom);
    r.regwrite = 1'($urandom);
    r.memread  = 1'($urandom);
    r.memwrite = 1'($urandom);
    r.branch   = 1'($urandom);
    r.aluop    = 2'($urandom);
    r.rs1Data  = {$urandom, $urandom};
    r.rs2Data  = {$urandom, $urandom};
    r.imm      = {$urandom, $urandom};
    r.pc       = {$urandom, $urandom};
    r.rs1      = 5'($urandom_range(0, 7));
    r.rs2      = 5'($urandom_range(0, 7));
    r.rd       = 5'($urandom_range(0, 7));
    r.funct    = 4'($urandom);
    return r;
  endfunction

  // Drives one ID cycle, records what EX should show during it, then advances the model.
  task automatic applyStimulus(input instr_t ins, input logic flush, input logic rstIn);
    exp_t e;
    logic expStall;
    @(posedge clk);
    #2;
    rst             = rstIn;
    bus.id_flush    = flush;
    bus.id_valid    = ins.valid;
    bus.id_alusrc   = ins.alusrc;
    bus.id_memtoreg = ins.memtoreg;
    bus.id_regwrite = ins.regwrite;
    bus.id_memread  = ins.memread;
    bus.id_memwrite = ins.memwrite;
    bus.id_branch   = ins.branch;
    bus.id_aluop    = ins.aluop;
    bus.id_rs1_data = ins.rs1Data;
    bus.id_rs2_data = ins.rs2Data;
    bus.id_imm      = ins.imm;
    bus.id_pc       = ins.pc;
    bus.id_rs1      = ins.rs1;
    bus.id_rs2      = ins.rs2;
    bus.id_rd       = ins.rd;
    bus.id_funct    = ins.funct;

    expStall = 1'b0;
    if (modelKnown) begin
      expStall = loadUse(mEx, ins) && !flush && !rstIn;
      e.ex     = mEx;
      e.stall  = expStall;
      e.cnt    = mCnt;
      sbQ.push_back(e);
      running  = 1'b1;
    end
    lastStall = expStall;

    if (rstIn) begin
      mEx        = '0;
      mCnt       = 0;
      modelKnown = 1'b1;
    end else if (modelKnown) begin
      if (flush || loadUse(mEx, ins)) begin
        mEx = '0;
        if (mCnt < CNT_MAX) mCnt++;
      end else begin
        mEx = ins;
        if (!ins.valid) begin
          mEx.alusrc   = 1'b0;
          mEx.memtoreg = 1'b0;
          mEx.regwrite = 1'b0;
          mEx.memread  = 1'b0;
          mEx.memwrite = 1'b0;
          mEx.branch   = 1'b0;
          mEx.aluop    = 2'b00;
        end
      end
    end
  endtask

  // Monitor: every cycle the register presents an EX slot, compare it with the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (running) begin
        if (sbQ.size() == 0) begin
          nChecks++;
          nFails++;
          $display("[TB] FAIL scoreboardEmpty: got no expectation, expected one at %0t", $time);
        end else begin
          e = sbQ.pop_front();
          checkOutput("exValid", 64'(bus.ex_valid), 64'(e.ex.valid));
          checkOutput("exCtrl",
                      64'({bus.ex_alusrc, bus.ex_memtoreg, bus.ex_regwrite, bus.ex_memread,
                           bus.ex_memwrite, bus.ex_branch, bus.ex_aluop}),
                      64'({e.ex.alusrc, e.ex.memtoreg, e.ex.regwrite, e.ex.memread,
                           e.ex.memwrite, e.ex.branch, e.ex.aluop}));
          checkOutput("exRs1Data", bus.ex_rs1_data, e.ex.rs1Data);
          checkOutput("exRs2Data", bus.ex_rs2_data, e.ex.rs2Data);
          checkOutput("exImm", bus.ex_imm, e.ex.imm);
          checkOutput("exPc", bus.ex_pc, e.ex.pc);
          checkOutput("exRegs", 64'({bus.ex_rs1, bus.ex_rs2, bus.ex_rd}),
                      64'({e.ex.rs1, e.ex.rs2, e.ex.rd}));
          checkOutput("exFunct", 64'(bus.ex_funct), 64'(e.ex.funct));
          checkOutput("stall", 64'(bus.stall), 64'(e.stall));
          checkOutput("bubbleCnt", 64'(bus.bubble_cnt), 64'(e.cnt));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL timeout: simulation did not reach the end, expected completion");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    instr_t nop, rtype, ld, add, sub, cur;
    logic   fl;
    rst = 1'b1;
    bus.id_flush = 1'b0;
    bus.id_valid = 1'b0;

    nop = '0;
    nop.valid = 1'b1;
    nop.rd    = 5'd0;
    nop.rs1   = 5'd0;
    nop.rs2   = 5'd0;

    $display("[TB] reset with random ID inputs");
    for (int i = 0; i < 3; i++) applyStimulus(randInstr(), 1'($urandom), 1'b1);

    $display("[TB] passthrough");
    rtype          = '0;
    rtype.valid    = 1'b1;
    rtype.regwrite = 1'b1;
    rtype.aluop    = 2'b10;
    rtype.rs1Data  = 64'h1234;
    rtype.rs2Data  = 64'h55;
    rtype.rs1      = 5'd1;
    rtype.rs2      = 5'd2;
    rtype.rd       = 5'd7;
    rtype.pc       = 64'h100;
    applyStimulus(rtype, 1'b0, 1'b0);

    $display("[TB] load-use");
    ld          = '0;
    ld.valid    = 1'b1;
    ld.memread  = 1'b1;
    ld.regwrite = 1'b1;
    ld.memtoreg = 1'b1;
    ld.alusrc   = 1'b1;
    ld.rs1      = 5'd2;
    ld.rd       = 5'd5;
    ld.imm      = 64'h8;
    ld.pc       = 64'h104;
    add          = '0;
    add.valid    = 1'b1;
    add.regwrite = 1'b1;
    add.aluop    = 2'b10;
    add.rs1      = 5'd5;
    add.rs2      = 5'd1;
    add.rd       = 5'd6;
    add.pc       = 64'h108;
    applyStimulus(ld, 1'b0, 1'b0);
    applyStimulus(add, 1'b0, 1'b0);
    #1 checkOutput("loadUseStall", 64'(bus.stall), 64'd1);
    applyStimulus(add, 1'b0, 1'b0);
    #1 checkOutput("stallReleased", 64'(bus.stall), 64'd0);
    checkOutput("bubbleAfterLoadUse", 64'(bus.bubble_cnt), 64'd1);
    applyStimulus(nop, 1'b0, 1'b0);

    $display("[TB] x0 load and non-matching sources");
    cur    = ld;
    cur.rd = 5'd0;
    applyStimulus(cur, 1'b0, 1'b0);
    cur     = add;
    cur.rs1 = 5'd0;
    cur.rs2 = 5'd0;
    applyStimulus(cur, 1'b0, 1'b0);
    #1 checkOutput("x0NoStall", 64'(bus.stall), 64'd0);
    applyStimulus(ld, 1'b0, 1'b0);
    cur     = add;
    cur.rs1 = 5'd3;
    cur.rs2 = 5'd4;
    applyStimulus(cur, 1'b0, 1'b0);
    #1 checkOutput("noMatchNoStall", 64'(bus.stall), 64'd0);
    applyStimulus(nop, 1'b0, 1'b0);
    checkOutput("noExtraBubbles", 64'(bus.bubble_cnt), 64'd1);

    $display("[TB] flush during hazard");
    applyStimulus(ld, 1'b0, 1'b0);
    applyStimulus(add, 1'b1, 1'b0);
    #1 checkOutput("flushBeatsStall", 64'(bus.stall), 64'd0);
    sub         = rtype;
    sub.funct   = 4'b1000;
    sub.rd      = 5'd9;
    sub.pc      = 64'h200;
    applyStimulus(sub, 1'b0, 1'b0);
    checkOutput("flushCountedOnce", 64'(bus.bubble_cnt), 64'd2);
    applyStimulus(nop, 1'b0, 1'b0);

    $display("[TB] bubble counter saturation");
    for (int i = 0; i < 20; i++) applyStimulus(randInstr(), 1'b1, 1'b0);
    applyStimulus(nop, 1'b0, 1'b0);
    checkOutput("cntSaturated", 64'(bus.bubble_cnt), 64'(CNT_MAX));
    applyStimulus(nop, 1'b1, 1'b0);
    applyStimulus(nop, 1'b0, 1'b1);
    checkOutput("cntHeld", 64'(bus.bubble_cnt), 64'(CNT_MAX));
    applyStimulus(nop, 1'b0, 1'b0);
    checkOutput("cntCleared", 64'(bus.bubble_cnt), 64'd0);

    $display("[TB] random traffic");
    cur = randInstr();
    for (int i = 0; i < 400; i++) begin
      if (!lastStall) cur = randInstr();
      fl = ($urandom_range(0, 9) == 0);
      applyStimulus(cur, fl, ($urandom_range(0, 49) == 0));
    end

    @(negedge clk);
    #1;
    running = 1'b0;
    if (sbQ.size() != 0) begin
      nChecks++;
      nFails++;
      $display("[TB] FAIL scoreboardDrain: got %0d pending, expected 0", sbQ.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/id_ex_hazard_reg.md
Name: id_ex_hazard_reg

Overview:
- Decode-to-execute pipeline register for the 5-stage RISC-V core. Sits directly downstream of CONTROL_UNIT.
- Captures the decoded control bits, register-file read data, immediate and register addresses each cycle, and presents them to the EX stage.
- Contains the load-use hazard detector. On a hazard it stalls PC/IF-ID and injects a bubble. On a branch flush it also injects a bubble.
- Keeps a saturating bubble counter for performance monitoring.

Parameters:
- XLEN, 64, datapath width (register data, immediate, PC)
- RA_W, 5, register address width
- CNT_W, 16, bubble counter width

Ports:
- clk  input  1  single clock, rising edge
- rst  input  1  synchronous reset, active-high
- id_valid  input  1  ID stage holds a real instruction
- id_flush  input  1  branch taken in EX/MEM; kill the instruction currently in ID
- id_alusrc, id_memtoreg, id_regwrite, id_memread, id_memwrite, id_branch  input  1 each  from CONTROL_UNIT
- id_aluop  input  2  from CONTROL_UNIT
- id_rs1_data, id_rs2_data, id_imm, id_pc  input  XLEN each
- id_rs1, id_rs2, id_rd  input  RA_W each
- id_funct  input  4  {funct7[5], funct3}
- ex_valid  output  1
- ex_alusrc, ex_memtoreg, ex_regwrite, ex_memread, ex_memwrite, ex_branch  output  1 each
- ex_aluop  output  2
- ex_rs1_data, ex_rs2_data, ex_imm, ex_pc  output  XLEN each
- ex_rs1, ex_rs2, ex_rd  output  RA_W each
- ex_funct  output  4
- stall  output  1  combinational; when high, the PC and IF/ID register must not update
- bubble_cnt  output  CNT_W  saturating count of injected bubbles

Behaviour:
- Clock and reset: clk and rst. rst is synchronous and active-high. It is sampled on the rising edge and has priority over all other inputs.
- Reset values: all ex_* outputs are 0 (ex_valid=0, every control bit 0, ex_aluop=2'b00, all data and address fields 0). bubble_cnt=0.
- Hazard detection (combinational, from current ex_* registers and id_* inputs):
  - hazard = id_valid & ex_valid & ex_memread & (ex_rd != 0) & ((ex_rd == id_rs1) | (ex_rd == id_rs2))
  - id_rs2 is compared regardless of instruction format. This is conservative and intended.
  - stall = hazard & ~id_flush & ~rst.
- Register update on each rising edge, in priority order:
  1. rst: load reset values.
  2. id_flush: bubble. Load ex_valid=0 and all eight control bits 0. Data, address and funct fields load 0. bubble_cnt increments.
  3. hazard: bubble, same as 2. The ID instruction is retained upstream because stall=1, and it re-presents next cycle. bubble_cnt increments.
  4. Otherwise: load every id_* field into the matching ex_* field. ex_valid = id_valid. If id_valid=0, the control bits are forced to 0. This is not counted as a bubble.
- Latency: exactly 1 cycle from ID inputs to EX outputs. There is no combinational path from id_* to ex_*.
- A load-use stall lasts exactly 1 cycle. After the bubble, ex_memread=0, so hazard drops and the stalled instruction proceeds.
- Flush and hazard in the same cycle: flush wins and stall=0. The killed instruction is never retried.
- bubble_cnt saturates at 2^CNT_W-1. At saturation it holds, with no wrap. It is cleared only by rst.
- ex_rd=0 never creates a hazard (x0 is hardwired to zero).
- Reset asserted mid-stall: the next edge clears everything and stall drops combinationally while rst=1.

Test Plan:
1. Reset: hold rst=1 for 2 cycles with random id_* inputs -> all ex_* outputs are 0, bubble_cnt=0, stall=0.
2. Passthrough: id_valid=1, R-type controls (regwrite=1, aluop=2'b10), rs1_data=0x1234, rd=7 -> the next cycle shows the same values on ex_*, ex_valid=1, stall=0.
3. Load-use: issue ld x5 (memread=1, rd=5), then add x6,x5,x1 (rs1=5) -> in the add's ID cycle stall=1. The next cycle has ex_valid=0 with all controls 0 and bubble_cnt=1. The following cycle the add reaches EX with stall=0.
4. x0 and no-match: ld x0 followed by a use of x0, and ld x5 followed by an instruction with rs1=3, rs2=4 -> stall=0 in both cases and no bubble.
5. Flush during a hazard: set up a load-use pair and assert id_flush in the hazard cycle -> stall=0, a bubble is loaded, bubble_cnt increments once, and the killed instruction does not reappear.
6. Saturation: run with CNT_W=4 and force 20 consecutive flushes -> bubble_cnt reaches 15 and holds there. A subsequent rst clears it to 0.
